// File: rtl/v_counter.sv
// rtl/v_counter.sv - vertical half of the 640x480@60 VGA raster: line count, registered syncs, video_on, frame tick
module v_counter #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Window boundaries as 10-bit constants so every compare is unsigned 10-bit.
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic trig_prev;
    logic line_edge;
    logic at_last_line;
    logic h_in_sync;
    logic v_in_sync;
    logic in_visible;

    // Rising-edge detect and window decodes from the current counts.
    always_comb begin
        line_edge    = trig_v & ~trig_prev;
        at_last_line = (v_count == V_LAST);
        h_in_sync    = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
        v_in_sync    = (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);
        in_visible   = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    end

    // Trigger history tracks trig_v even in reset, so a trigger held across release is not counted.
    always_ff @(posedge clk) begin
        trig_prev <= trig_v;
    end

    // Line counter and frame tick; the tick fires on the same edge that wraps to line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_count    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= line_edge & at_last_line;
            if (line_edge) begin
                v_count <= at_last_line ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    // Registered sync/visible decodes, one clock behind their source counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            hsync    <= ~h_in_sync;
            vsync    <= ~v_in_sync;
            video_on <= in_visible;
        end
    end

endmodule
